rotary_button_decoder: RTL

//  Front-end input stage for the I2C master test-menu controller. Synchronises the

---
 rtl/rotary_button_decoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rotary_button_decoder.sv
// rotary_button_decoder
// Input stage for the test-menu controller. All six raw inputs are synchronised
// through two flops each. The rotary encoder is decoded into one-cycle detent steps
// with a direction flag. The four buttons are debounced into stable levels and
// one-cycle press strobes. Every output comes straight from a flop.
module rotary_button_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rotary_a,
  input  logic       rotary_b,
  input  logic       rotary_center,
  input  logic       btn_west,
  input  logic       btn_east,
  input  logic       btn_north,
  output logic       rot_step,
  output logic       rot_dir,
  output logic       center_press,
  output logic       west_press,
  output logic       east_press,
  output logic       north_press,
  output logic [3:0] btn_state
);

  // Last counter value before a differing level is accepted, and the increment step.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Raw input vector: [0]=a, [1]=b, [5:2]={north, east, west, center}.
  logic [5:0] raw_s;

  logic [5:0] sync1_q, sync1_d;
  logic [5:0] sync2_q, sync2_d;

  logic       rot_a_s, rot_b_s;
  logic       q1_q, q1_d;
  logic       q2_q, q2_d;
  logic       q1_dly_q, q1_dly_d;
  logic       rot_step_q, rot_step_d;
  logic       rot_dir_q, rot_dir_d;

  logic [3:0]       btn_lvl_s;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign raw_s = {btn_north, btn_east, btn_west, rotary_center, rotary_b, rotary_a};

  // Next values of the two synchroniser stages: stage 1 samples the pins, stage 2 follows stage 1
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
  end

  // Synchroniser flops; nothing downstream ever sees the raw pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 6'd0;
      sync2_q <= 6'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign rot_a_s   = sync2_q[0];
  assign rot_b_s   = sync2_q[1];
  assign btn_lvl_s = sync2_q[5:2];

  // Quadrature filter: q1 only moves on 11/00 so single-phase bounce cannot make a detent
  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    case ({rot_a_s, rot_b_s})
      2'b11: q1_d = 1'b1;
      2'b00: q1_d = 1'b0;
      2'b10: q2_d = 1'b1;
      2'b01: q2_d = 1'b0;
      default: begin
        q1_d = q1_q;
        q2_d = q2_q;
      end
    endcase
    q1_dly_d   = q1_q;
    rot_step_d = q1_q & ~q1_dly_q;
    if (rot_step_d) begin
      // q2 remembers which phase was high alone last, i.e. which phase led
      rot_dir_d = ~q2_q;
    end else begin
      rot_dir_d = rot_dir_q;
    end
  end

  // Rotary filter state and registered step/direction outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1_q       <= 1'b0;
      q2_q       <= 1'b0;
      q1_dly_q   <= 1'b0;
      rot_step_q <= 1'b0;
      rot_dir_q  <= 1'b0;
    end else begin
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      q1_dly_q   <= q1_dly_d;
      rot_step_q <= rot_step_d;
      rot_dir_q  <= rot_dir_d;
    end
  end

  // Per-button debounce: a new level must persist unbroken for DEBOUNCE_CYCLES cycles
  always_comb begin
    stable_d = stable_q;
    press_d  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_lvl_s[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] >= CNT_LAST) begin
        // Accept the new level; only a rising acceptance is a press
        cnt_d[i]    = CNT_ZERO;
        stable_d[i] = btn_lvl_s[i];
        press_d[i]  = btn_lvl_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce counters, accepted levels and press strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 4'd0;
      press_q  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rot_step     = rot_step_q;
  assign rot_dir      = rot_dir_q;
  assign center_press = press_q[0];
  assign west_press   = press_q[1];
  assign east_press   = press_q[2];
  assign north_press  = press_q[3];
  assign btn_state    = stable_q;

endmodule
